// File: rtl/clock_rate_controller.sv
// Run/stop, runtime-reprogrammable sequencer for the system clock divider.
// Divisor updates arrive over a valid/ready handshake and only take effect on
// a period boundary, so clock_out never emits a runt pulse. A one-cycle tick
// marks the first cycle of every period for logic clocked on clock_in.
//
// state | meaning
// ------+--------------------------------------------------------------
// STOP  | divider idle, counter held at 0, clock_out low
// RUN   | divider running, no update waiting
// PEND  | divider running, accepted divisor waiting for the wrap edge
module clock_rate_controller #(
   parameter int WIDTH       = 28,
   parameter int DEFAULT_DIV = 25000,
   parameter int MIN_DIV     = 2
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             run,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_divisor,
   output logic             cfg_ready,
   output logic             cfg_error,
   output logic [WIDTH-1:0] active_divisor,
   output logic             clock_out,
   output logic             tick,
   output logic             running
);

   localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] MIN_D = WIDTH'(MIN_DIV);
   localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] counter;
   logic [WIDTH-1:0] pending;
   logic [WIDTH-1:0] half_div;
   logic             wrap;
   logic             xfer;
   logic             xfer_ok;
   logic             xfer_bad;

   // Handshake and period-boundary decode, all from registered state.
   assign cfg_ready = (state != ST_PEND);
   assign running   = (state != ST_STOP);
   assign half_div  = active_divisor >> 1;
   assign wrap      = running && (counter == active_divisor - ONE);
   assign xfer      = cfg_valid && cfg_ready;
   assign xfer_ok   = xfer && (cfg_divisor >= MIN_D);
   assign xfer_bad  = xfer && (cfg_divisor < MIN_D);

   // Sequencer: counter, divisor hand-over, and registered clock/tick outputs.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_STOP;
         counter        <= '0;
         pending        <= '0;
         active_divisor <= DEF_D;
         clock_out      <= 1'b0;
         tick           <= 1'b0;
         cfg_error      <= 1'b0;
      end else begin
         cfg_error <= xfer_bad;
         tick      <= wrap;
         clock_out <= running && (counter < half_div);
         case (state)
            ST_STOP: begin
               counter <= '0;
               if (xfer_ok) active_divisor <= cfg_divisor;
               if (run) state <= ST_RUN;
            end
            ST_RUN: begin
               counter <= wrap ? '0 : counter + ONE;
               // An update landing exactly on the wrap edge needs no parking.
               if (xfer_ok && wrap) begin
                  active_divisor <= cfg_divisor;
               end else if (xfer_ok) begin
                  pending <= cfg_divisor;
                  state   <= ST_PEND;
               end
               if (wrap && !run) state <= ST_STOP;
            end
            ST_PEND: begin
               counter <= wrap ? '0 : counter + ONE;
               if (wrap) begin
                  active_divisor <= pending;
                  state          <= run ? ST_RUN : ST_STOP;
               end
            end
            default: begin
               state   <= ST_STOP;
               counter <= '0;
            end
         endcase
      end
   end

endmodule
